// File: rtl/ram_pkg.sv
// Shared parameters and FSM state type for the RAM burst master and its RAM.
package ram_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    FLUSH = 2'd3
  } ram_mst_state_t;

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM: registered read with one-cycle latency, write on en & wr_en.
module single_port_ram #(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr_en) mem[address] <= data_in;
      else       data_out     <= mem[address];
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for single_port_ram: one word per cycle, writes streamed from
// a valid/ready beat port, reads returned on a valid-only port.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              done,
  output logic              ram_en,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output ram_mst_state_t    state_dbg
);

  // Handshakes: a transfer happens on a cycle where valid & ready are both
  // high; valid never waits on ready. The read port has no ready.

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  ram_mst_state_t    state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ptr   <= cmd_addr;
            cnt   <= cmd_len;
            state <= cmd_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_data_valid) begin
            ptr <= ptr + ADDR_ONE;
            cnt <= cnt - ADDR_ONE;
            if (cnt == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          // The word issued now appears on ram_data_out next cycle.
          rd_pend   <= 1'b1;
          rd_addr_q <= ptr;
          ptr       <= ptr + ADDR_ONE;
          cnt       <= cnt - ADDR_ONE;
          if (cnt == '0) state <= FLUSH;
        end
        FLUSH: begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are forced low while rst is high, whatever the registered state.
  always_comb begin
    cmd_ready     = 1'b0;
    wr_data_ready = 1'b0;
    ram_en        = 1'b0;
    ram_wr_en     = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:  cmd_ready = 1'b1;
        WRITE: begin
          wr_data_ready = 1'b1;
          ram_en        = wr_data_valid;
          ram_wr_en     = wr_data_valid;
        end
        READ:    ram_en = 1'b1;
        default: ;
      endcase
    end
  end

  assign ram_address = ptr;
  assign ram_data_in = wr_data;
  assign rd_valid    = rd_pend & ~rst;
  assign rd_data     = ram_data_out;
  assign rd_addr     = rd_addr_q;
  assign done        = done_q & ~rst;
  assign state_dbg   = state;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master driving a single_port_ram, checked against an
// array model of RAM contents and a cycle schedule derived from burst length.
module tb_ram_burst_master;
  import ram_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_W-1:0]   cmd_addr, cmd_len;
  logic                wr_data_valid, wr_data_ready;
  logic [DATA_W-1:0]   wr_data;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic [ADDR_W-1:0]   rd_addr;
  logic                done;
  logic                ram_en, ram_wr_en;
  logic [ADDR_W-1:0]   ram_address;
  logic [DATA_W-1:0]   ram_data_in, ram_data_out;
  ram_mst_state_t      state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] exp_a_q [$];
  logic [DATA_W-1:0] wr_src [$];
  bit                done_due = 1'b0;

  ram_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_addr(rd_addr), .done(done),
    .ram_en(ram_en), .ram_wr_en(ram_wr_en), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .state_dbg(state_dbg)
  );

  single_port_ram ram (
    .clk(clk), .en(ram_en), .wr_en(ram_wr_en), .address(ram_address),
    .data_in(ram_data_in), .data_out(ram_data_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // {cmd_ready, wr_data_ready, ram_en, ram_wr_en, rd_valid, done}
  function automatic logic [5:0] ctl();
    return {cmd_ready, wr_data_ready, ram_en, ram_wr_en, rd_valid, done};
  endfunction

  // ---------------- driver tasks ----------------
  // Starts in a drive slot; returns in the slot where done is expected.
  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len,
                          input int stall_beat, input int stall_n, input int rst_beat);
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = addr; cmd_len = len;
    wr_data_valid = 1'b0;
    sample();
    n_checks++;
    if (ctl() !== {5'b10000, done_due})
      $display("FAIL wr_cmd ctl got %b want %b", ctl(), {5'b10000, done_due});
    else n_pass++;
    done_due = 1'b0;
    next_slot();
    cmd_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          wr_data_valid = 1'b0;
          sample();
          n_checks++;
          if (ctl() !== 6'b010000) $display("FAIL wr_stall ctl got %b want 010000", ctl());
          else n_pass++;
          next_slot();
        end
      end
      d = (wr_src.size() != 0) ? wr_src.pop_front() : DATA_W'($urandom);
      a = addr + ADDR_W'(b);
      wr_data = d; wr_data_valid = 1'b1;
      if (b == rst_beat) begin
        rst = 1'b1;
        sample();
        n_checks++;
        if (ctl() !== 6'b000000) $display("FAIL rst_mid ctl got %b want 000000", ctl());
        else n_pass++;
        next_slot();
        rst = 1'b0; wr_data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
          sample();
          n_checks++;
          if (ctl() !== 6'b100000) $display("FAIL post_rst ctl got %b want 100000 (k=%0d)", ctl(), k);
          else n_pass++;
          next_slot();
        end
        return;
      end
      sample();
      n_checks++;
      if (ctl() !== 6'b011100) $display("FAIL wr_beat ctl got %b want 011100 (beat %0d)", ctl(), b);
      else n_pass++;
      n_checks++;
      if ({ram_address, ram_data_in} !== {a, d})
        $display("FAIL wr_pins addr/data got %0d/%h want %0d/%h", ram_address, ram_data_in, a, d);
      else n_pass++;
      model_mem[a] = d;
      next_slot();
    end
    wr_data_valid = 1'b0;
    done_due = 1'b1;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len);
    logic [DATA_W-1:0] ed;
    logic [ADDR_W-1:0] ea;
    bit issue, rv;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = addr; cmd_len = len;
    wr_data_valid = 1'b0;
    sample();
    n_checks++;
    if (ctl() !== {5'b10000, done_due})
      $display("FAIL rd_cmd ctl got %b want %b", ctl(), {5'b10000, done_due});
    else n_pass++;
    done_due = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ea = addr + ADDR_W'(i);
      exp_q.push_back(model_mem[ea]);
      exp_a_q.push_back(ea);
    end
    next_slot();
    cmd_valid = 1'b0;
    // n words: issue in cycles 1..n, returns in 2..n+1
    for (int k = 1; k <= int'(len) + 2; k++) begin
      issue = (k <= int'(len) + 1);
      rv    = (k >= 2);
      sample();
      n_checks++;
      if (ctl() !== {2'b00, issue, 1'b0, rv, 1'b0})
        $display("FAIL rd_ctl got %b want %b (cycle %0d)", ctl(), {2'b00, issue, 1'b0, rv, 1'b0}, k);
      else n_pass++;
      if (issue) begin
        n_checks++;
        if (ram_address !== addr + ADDR_W'(k - 1))
          $display("FAIL rd_issue_addr got %0d want %0d", ram_address, addr + ADDR_W'(k - 1));
        else n_pass++;
      end
      if (rv) begin
        ed = exp_q.pop_front();
        ea = exp_a_q.pop_front();
        n_checks++;
        if ({rd_addr, rd_data} !== {ea, ed})
          $display("FAIL rd_data addr/data got %0d/%h want %0d/%h", rd_addr, rd_data, ea, ed);
        else n_pass++;
      end
      next_slot();
    end
    done_due = 1'b1;
  endtask

  task automatic expect_done();
    cmd_valid = 1'b0;
    sample();
    n_checks++;
    if (ctl() !== 6'b100001) $display("FAIL done_pulse ctl got %b want 100001", ctl());
    else n_pass++;
    next_slot();
    sample();
    n_checks++;
    if (ctl() !== 6'b100000) $display("FAIL done_clear ctl got %b want 100000", ctl());
    else n_pass++;
    next_slot();
    done_due = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = '0; cmd_len = '0;
    wr_data_valid = 1'b1; wr_data = '0;
    next_slot(); next_slot();
    sample();
    n_checks++;
    if (ctl() !== 6'b000000) $display("FAIL reset_ctl got %b want 000000", ctl());
    else n_pass++;
    next_slot();
    rst = 1'b0; cmd_valid = 1'b0; wr_data_valid = 1'b0;
    sample();
    n_checks++;
    if (ctl() !== 6'b100000) $display("FAIL reset_idle got %b want 100000", ctl());
    else n_pass++;
    next_slot();
  endtask

  task automatic test_fill();
    do_write(4'd0, 4'd15, -1, 0, -1);
    expect_done();
  endtask

  task automatic test_basic();
    wr_src = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(4'd0, 4'd3, -1, 0, -1);
    expect_done();
    do_read(4'd0, 4'd3);
    expect_done();
  endtask

  task automatic test_wrap();
    wr_src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(4'd14, 4'd3, -1, 0, -1);
    expect_done();
    do_read(4'd14, 4'd3);
    expect_done();
  endtask

  task automatic test_stall();
    do_write(4'd5, 4'd2, 1, 2, -1);
    expect_done();
    do_read(4'd5, 4'd2);
    expect_done();
  endtask

  task automatic test_back_to_back();
    do_write(4'd3, 4'd1, -1, 0, -1);
    do_read(4'd2, 4'd3);
    do_read(4'd9, 4'd0);
    do_write(4'd15, 4'd2, -1, 0, -1);
    do_write(4'd8, 4'd0, -1, 0, -1);
    do_read(4'd14, 4'd4);
    expect_done();
  endtask

  task automatic test_reset_mid();
    do_write(4'd0, 4'd15, -1, 0, 8);
    do_read(4'd0, 4'd15);
    expect_done();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a, l;
    for (int i = 0; i < 12; i++) begin
      if (done_due && $urandom_range(0, 1) == 0) expect_done();
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      l = ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1)
        do_write(a, l, $urandom_range(0, int'(l)), $urandom_range(0, 3), -1);
      else
        do_read(a, l);
    end
    if (done_due) expect_done();
    do_read(4'd0, 4'd15);
    expect_done();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data_valid = 1'b0; wr_data = '0;
    test_reset();
    test_fill();
    test_basic();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Initiator for the team's 16x8 single-port RAM (`single_port_ram`: registered read, one-cycle read latency, write on `en & wr_en`). It accepts burst commands over a valid/ready handshake and drives the RAM `en`/`wr_en`/`address`/`data_in` pins one word per cycle. Write bursts take data from a streaming write port; read bursts return data on a valid-qualified read port. It sits between host-side control logic and the RAM instance.

## Interface
- `ADDR_W`, 4, RAM address width; depth is 2^ADDR_W.
- `DATA_W`, 8, RAM data width.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_wr`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  ADDR_W  start address.
- `cmd_len`  in  ADDR_W  burst length minus 1 (0 gives 1 word, 15 gives 16 words).
- `wr_data_valid`  in  1  write beat present.
- `wr_data_ready`  out  1  write beat consumed when `wr_data_valid & wr_data_ready`.
- `wr_data`  in  DATA_W  write beat.
- `rd_valid`  out  1  `rd_data`/`rd_addr` valid this cycle. There is no backpressure.
- `rd_data`  out  DATA_W  read word.
- `rd_addr`  out  ADDR_W  address of `rd_data`.
- `done`  out  1  one-cycle pulse when a burst completes.
- `ram_en`, `ram_wr_en`  out  1  to RAM `en`, `wr_en`.
- `ram_address`  out  ADDR_W  to RAM `address`.
- `ram_data_in`  out  DATA_W  to RAM `data_in`.
- `ram_data_out`  in  DATA_W  from RAM `data_out`.

## Operation
- **States:** IDLE, WRITE, READ, FLUSH.
- **IDLE**
  - `cmd_ready` = 1.
  - On handshake: latch `ptr <= cmd_addr` and `cnt <= cmd_len`.
  - Go to WRITE if `cmd_wr`, else READ.
- **WRITE**
  - `wr_data_ready` = 1.
  - RAM pins are combinational: `ram_en = ram_wr_en = wr_data_valid`, `ram_address = ptr`, `ram_data_in = wr_data`.
  - Each accepted beat: `ptr <= ptr+1`, `cnt <= cnt-1`.
  - Beat accepted with `cnt == 0`: go to IDLE and set `done`.
  - `wr_data_valid` low stalls the burst: `ram_en` = 0 and nothing advances.
- **READ**
  - Every cycle: `ram_en` = 1, `ram_wr_en` = 0, `ram_address = ptr`.
  - Register `rd_pend <= 1` and `rd_addr <= ptr`; then `ptr++` and `cnt--`.
  - On `cnt == 0`: go to FLUSH.
- **FLUSH**
  - `ram_en` = 0; the last word emerges this cycle.
  - Go to IDLE and set `done`.
- **Read return path**
  - `rd_valid = rd_pend`.
  - `rd_data = ram_data_out`, passed straight through with no extra register.
- **Address arithmetic:** `ptr` increments modulo 2^ADDR_W, so 15 wraps to 0. A 16-word burst from any start address covers every location exactly once.
- **Idle outputs:** outside WRITE/READ, `ram_en` = 0 and `wr_data_ready` = 0. `ram_address`/`ram_data_in` hold the last value; they are don't-care.
- **`done`:** registered. It is high during the first IDLE cycle after a burst, together with `cmd_ready` = 1. A new command may be accepted in that same cycle.
- **Reset (any state, including mid-burst)**
  - Next state IDLE; `ptr`, `cnt`, `rd_pend`, `rd_addr`, `done` all cleared.
  - While `rst` = 1: `cmd_ready`, `wr_data_ready`, `ram_en`, `ram_wr_en`, `rd_valid`, `done` are all 0.
  - RAM contents are not touched. A partially written burst leaves the already-written words in place.

## Timing
- Command handshake in cycle 0 gives first RAM access in cycle 1.
- **Read burst of n words**
  - Issues in cycles 1..n.
  - `rd_valid` in cycles 2..n+1, back-to-back, addresses in order.
  - FLUSH in cycle n+1; `done` and `cmd_ready` in cycle n+2.
- **Write burst:** `done` comes one cycle after the final accepted beat, so n cycles + 1 when no stalls.
- **Throughput:** one word per cycle. Minimum back-to-back command spacing: n+2 cycles (read), n+1 cycles (write).
- Host write data reaches `ram_data_in` combinationally. The RAM captures it on the edge ending that cycle.

## Structure
- Package `ram_pkg`:
  - `ADDR_W` and `DATA_W` defaults.
  - `DEPTH = 1 << ADDR_W`.
  - State typedef `ram_mst_state_t` {IDLE, WRITE, READ, FLUSH}.
- Single module. No sub-module is required.
- The bench instantiates `single_port_ram` as the responder, wired pin-to-pin.

## Test plan
- Reset, then write burst addr 0, len 3, data 0x11,0x22,0x33,0x44 with no stalls -> RAM[0..3] = 0x11..0x44; `done` in cycle 5; `ram_en` high in cycles 1-4 only.
- Read burst addr 0, len 3 after the above -> `rd_valid` cycles 2-5 with (0,0x11),(1,0x22),(2,0x33),(3,0x44); `done` in cycle 6.
- Write addr 14, len 3 (0xA0..0xA3), then read addr 14, len 3 -> addresses 14,15,0,1 returning 0xA0..0xA3 (wrap-around).
- Write burst len 2 with `wr_data_valid` low for 2 cycles after beat 0 -> no RAM write during the gap; `done` 6 cycles after command accept; data intact.
- Full 16-word write (`len` 15), `rst` asserted after beat 8 -> RAM[0..7] written, RAM[8..15] unchanged; after reset `cmd_ready` = 1, `done` never pulsed, `rd_valid` = 0.
- New command presented during the `done` cycle -> accepted immediately; next burst starts the following cycle.
